// File: rtl/apb_reg_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apb_reg_seq_pkg
//  Description : Shared types and constants for the APB register-bank
//                configuration sequencer (FSM states, response error codes,
//                register stride of the target bank).
//  Revision    : 1.0 - initial release
// ============================================================================
package apb_reg_seq_pkg;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Response error codes returned on rsp_err_o
    typedef enum logic [1:0] {
        ERR_OK  = 2'd0,
        ERR_SLV = 2'd1,
        ERR_TMO = 2'd2,
        ERR_DEC = 2'd3
    } err_t;

    // Byte distance between consecutive registers in the target bank
    localparam int unsigned REG_STRIDE = 4;

endpackage : apb_reg_seq_pkg
`default_nettype wire

// File: rtl/apb_reg_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : apb_reg_rr_arb
//  Description : Combinational round-robin arbiter. The lowest requesting
//                index at or after ptr (wrapping) wins.
//  Ports       : req     - request vector, one bit per requester
//                ptr     - round-robin start index
//                en      - arbitration enable; no grant when low
//                gnt     - one-hot grant (zero when nothing granted)
//                gnt_idx - binary index of the granted requester
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_reg_rr_arb #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    input  logic                       en,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic found;
    int   cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = 0;
        // Scan starting at ptr; ptr is always < NUM_REQ so the modulo wraps
        // correctly for non-power-of-two requester counts.
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(ptr) + i) % NUM_REQ;
            if (en && !found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = IDX_W'(cand);
            end
        end
    end

endmodule : apb_reg_rr_arb
`default_nettype wire

// File: rtl/apb_reg_cfg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : apb_reg_cfg_sequencer
//  Description : APB master sharing one register-bank slave between NUM_REQ
//                requesters. Round-robin accepts one command at a time in
//                IDLE, checks the offset locally, runs the APB SETUP/ACCESS
//                phases with a pready timeout and returns a one-cycle
//                response to the granted requester.
//  Ports       : p_clk, p_rst_n        - clock, synchronous active-low reset
//                req_*_i / req_ready_o - per-requester command channel
//                                        (flattened vectors, requester r at
//                                        slice [r*W +: W])
//                rsp_*_o               - response pulse, shared rdata/err
//                apb_reg_*             - APB master interface
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_reg_cfg_sequencer
    import apb_reg_seq_pkg::*;
#(
    parameter int                        NUM_REQ        = 2,
    parameter int                        APB_ADDR_WIDTH = 32,
    parameter int                        APB_DATA_WIDTH = 32,
    parameter int                        NO_APB_REGS    = 342,
    parameter logic [APB_ADDR_WIDTH-1:0] BASE_ADDR      = APB_ADDR_WIDTH'(32'h0013_0000),
    parameter int                        TIMEOUT_CYCLES = 16,
    parameter int                        STRB_WIDTH     = APB_DATA_WIDTH / 8
) (
    input  logic                               p_clk,
    input  logic                               p_rst_n,
    input  logic [NUM_REQ-1:0]                 req_valid_i,
    output logic [NUM_REQ-1:0]                 req_ready_o,
    input  logic [NUM_REQ-1:0]                 req_write_i,
    input  logic [NUM_REQ*APB_ADDR_WIDTH-1:0]  req_offs_i,
    input  logic [NUM_REQ*APB_DATA_WIDTH-1:0]  req_wdata_i,
    input  logic [NUM_REQ*STRB_WIDTH-1:0]      req_strb_i,
    output logic [NUM_REQ-1:0]                 rsp_valid_o,
    output logic [APB_DATA_WIDTH-1:0]          rsp_rdata_o,
    output logic [1:0]                         rsp_err_o,
    output logic [APB_ADDR_WIDTH-1:0]          apb_reg_paddr,
    output logic [2:0]                         apb_reg_pprot,
    output logic                               apb_reg_psel,
    output logic                               apb_reg_penable,
    output logic                               apb_reg_pwrite,
    output logic [APB_DATA_WIDTH-1:0]          apb_reg_pwdata,
    output logic [STRB_WIDTH-1:0]              apb_reg_pstrb,
    input  logic                               apb_reg_pready,
    input  logic [APB_DATA_WIDTH-1:0]          apb_reg_prdata,
    input  logic                               apb_reg_pslverr
);

    localparam int                        IDX_W      = $clog2(NUM_REQ);
    localparam int                        CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]          CNT_LIMIT  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [APB_ADDR_WIDTH-1:0] ADDR_LIMIT = APB_ADDR_WIDTH'(REG_STRIDE * NO_APB_REGS);

    state_t                    state;
    state_t                    state_nxt;
    logic [IDX_W-1:0]          ptr;
    logic [IDX_W-1:0]          gnt_idx_q;
    logic                      write_q;
    logic [APB_ADDR_WIDTH-1:0] offs_q;
    logic [APB_DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0]     strb_q;
    logic [APB_DATA_WIDTH-1:0] rdata_q;
    err_t                      err_q;
    logic [CNT_W-1:0]          cnt;

    logic [NUM_REQ-1:0]        arb_gnt;
    logic [IDX_W-1:0]          arb_idx;
    logic                      accept;
    logic [APB_ADDR_WIDTH-1:0] offs_in;
    logic                      dec_err_in;
    logic                      tmo_hit;
    logic                      in_apb;

    apb_reg_rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req     (req_valid_i),
        .ptr     (ptr),
        .en      (state == IDLE),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    assign req_ready_o = arb_gnt;
    assign accept      = |arb_gnt;
    assign offs_in     = req_offs_i[int'(arb_idx)*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];

    // Decode is evaluated on the offset being latched so that a bad offset
    // can skip the APB phases and respond the cycle right after accept.
    assign dec_err_in  = (offs_in[1:0] != 2'b00) || (offs_in >= ADDR_LIMIT);
    assign tmo_hit     = (cnt == CNT_LIMIT);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge p_clk) begin
        if (!p_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = dec_err_in ? RESP : SETUP;
                end
            end
            SETUP: begin
                state_nxt = ACCESS;
            end
            ACCESS: begin
                // pready on the limit cycle still completes normally
                if (apb_reg_pready || tmo_hit) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Command latches, RR pointer, timeout counter and response capture
    // ------------------------------------------------------------------
    always_ff @(posedge p_clk) begin
        if (!p_rst_n) begin
            ptr       <= '0;
            gnt_idx_q <= '0;
            write_q   <= 1'b0;
            offs_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            rdata_q   <= '0;
            err_q     <= ERR_OK;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        gnt_idx_q <= arb_idx;
                        write_q   <= req_write_i[arb_idx];
                        offs_q    <= offs_in;
                        wdata_q   <= req_wdata_i[int'(arb_idx)*APB_DATA_WIDTH +: APB_DATA_WIDTH];
                        strb_q    <= req_strb_i[int'(arb_idx)*STRB_WIDTH +: STRB_WIDTH];
                        ptr       <= (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
                        cnt       <= '0;
                        rdata_q   <= '0;
                        err_q     <= dec_err_in ? ERR_DEC : ERR_OK;
                    end
                end
                ACCESS: begin
                    if (apb_reg_pready) begin
                        rdata_q <= write_q ? '0 : apb_reg_prdata;
                        err_q   <= apb_reg_pslverr ? ERR_SLV : ERR_OK;
                    end else if (tmo_hit) begin
                        rdata_q <= '0;
                        err_q   <= ERR_TMO;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // APB and response outputs; everything is zero outside its phase
    // ------------------------------------------------------------------
    assign in_apb = (state == SETUP) || (state == ACCESS);

    always_comb begin
        apb_reg_pprot   = 3'b000;
        apb_reg_psel    = in_apb;
        apb_reg_penable = (state == ACCESS);
        apb_reg_paddr   = '0;
        apb_reg_pwrite  = 1'b0;
        apb_reg_pwdata  = '0;
        apb_reg_pstrb   = '0;
        if (in_apb) begin
            apb_reg_paddr  = BASE_ADDR + offs_q;
            apb_reg_pwrite = write_q;
            apb_reg_pwdata = wdata_q;
            apb_reg_pstrb  = write_q ? strb_q : '0;
        end
    end

    always_comb begin
        rsp_valid_o = '0;
        rsp_rdata_o = '0;
        rsp_err_o   = 2'b00;
        if (state == RESP) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                rsp_valid_o[i] = (gnt_idx_q == IDX_W'(i));
            end
            rsp_rdata_o = rdata_q;
            rsp_err_o   = err_q;
        end
    end

endmodule : apb_reg_cfg_sequencer
`default_nettype wire

// File: tb/tb_apb_reg_cfg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_reg_cfg_sequencer
//  Description : Directed self-checking bench for apb_reg_cfg_sequencer with
//                two requesters and the default register bank geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_reg_cfg_sequencer;

    logic        p_clk = 1'b0;
    logic        p_rst_n;
    logic [1:0]  req_valid_i;
    logic [1:0]  req_ready_o;
    logic [1:0]  req_write_i;
    logic [63:0] req_offs_i;
    logic [63:0] req_wdata_i;
    logic [7:0]  req_strb_i;
    logic [1:0]  rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic [1:0]  rsp_err_o;
    logic [31:0] apb_reg_paddr;
    logic [2:0]  apb_reg_pprot;
    logic        apb_reg_psel;
    logic        apb_reg_penable;
    logic        apb_reg_pwrite;
    logic [31:0] apb_reg_pwdata;
    logic [3:0]  apb_reg_pstrb;
    logic        apb_reg_pready;
    logic [31:0] apb_reg_prdata;
    logic        apb_reg_pslverr;

    int checks   = 0;
    int failures = 0;

    always #5 p_clk = ~p_clk;

    apb_reg_cfg_sequencer dut (
        .p_clk           (p_clk),
        .p_rst_n         (p_rst_n),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_write_i     (req_write_i),
        .req_offs_i      (req_offs_i),
        .req_wdata_i     (req_wdata_i),
        .req_strb_i      (req_strb_i),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_rdata_o     (rsp_rdata_o),
        .rsp_err_o       (rsp_err_o),
        .apb_reg_paddr   (apb_reg_paddr),
        .apb_reg_pprot   (apb_reg_pprot),
        .apb_reg_psel    (apb_reg_psel),
        .apb_reg_penable (apb_reg_penable),
        .apb_reg_pwrite  (apb_reg_pwrite),
        .apb_reg_pwdata  (apb_reg_pwdata),
        .apb_reg_pstrb   (apb_reg_pstrb),
        .apb_reg_pready  (apb_reg_pready),
        .apb_reg_prdata  (apb_reg_prdata),
        .apb_reg_pslverr (apb_reg_pslverr)
    );

    task automatic set_req(input int r, input logic wr, input logic [31:0] offs,
                           input logic [31:0] wdata, input logic [3:0] strb);
        req_write_i[r]         = wr;
        req_offs_i[r*32 +: 32] = offs;
        req_wdata_i[r*32 +: 32] = wdata;
        req_strb_i[r*4 +: 4]   = strb;
    endtask

    task automatic test_reset();
        p_rst_n = 1'b0;
        repeat (2) @(negedge p_clk);
        #1;
        checks++; if (apb_reg_psel !== 1'b0) begin failures++; $display("FAIL reset_psel got=%b exp=0", apb_reg_psel); end
        checks++; if (apb_reg_penable !== 1'b0) begin failures++; $display("FAIL reset_penable got=%b exp=0", apb_reg_penable); end
        checks++; if (apb_reg_paddr !== 32'h0) begin failures++; $display("FAIL reset_paddr got=%h exp=0", apb_reg_paddr); end
        checks++; if (rsp_valid_o !== 2'b00) begin failures++; $display("FAIL reset_rsp got=%b exp=00", rsp_valid_o); end
        checks++; if (apb_reg_pprot !== 3'b000) begin failures++; $display("FAIL reset_pprot got=%b exp=000", apb_reg_pprot); end
        @(negedge p_clk);
        p_rst_n = 1'b1;
    endtask

    task automatic test_single_write();
        @(negedge p_clk);
        set_req(0, 1'b1, 32'h10, 32'hA5A5, 4'hF);
        req_valid_i = 2'b01;
        #1;
        checks++; if (req_ready_o !== 2'b01) begin failures++; $display("FAIL wr_ready got=%b exp=01", req_ready_o); end
        @(negedge p_clk); req_valid_i = 2'b00; #1;
        checks++; if (apb_reg_psel !== 1'b1 || apb_reg_penable !== 1'b0) begin failures++; $display("FAIL wr_setup psel/pen got=%b%b exp=10", apb_reg_psel, apb_reg_penable); end
        checks++; if (apb_reg_paddr !== 32'h0013_0010) begin failures++; $display("FAIL wr_paddr got=%h exp=00130010", apb_reg_paddr); end
        checks++; if (apb_reg_pwrite !== 1'b1) begin failures++; $display("FAIL wr_pwrite got=%b exp=1", apb_reg_pwrite); end
        checks++; if (apb_reg_pwdata !== 32'hA5A5 || apb_reg_pstrb !== 4'hF) begin failures++; $display("FAIL wr_data got=%h/%h exp=0000a5a5/f", apb_reg_pwdata, apb_reg_pstrb); end
        @(negedge p_clk); #1;
        checks++; if (apb_reg_psel !== 1'b1 || apb_reg_penable !== 1'b1) begin failures++; $display("FAIL wr_access psel/pen got=%b%b exp=11", apb_reg_psel, apb_reg_penable); end
        checks++; if (rsp_valid_o !== 2'b00) begin failures++; $display("FAIL wr_early_rsp got=%b exp=00", rsp_valid_o); end
        @(negedge p_clk); #1;
        checks++; if (rsp_valid_o !== 2'b01 || rsp_err_o !== 2'd0) begin failures++; $display("FAIL wr_rsp valid/err got=%b/%0d exp=01/0", rsp_valid_o, rsp_err_o); end
        checks++; if (rsp_rdata_o !== 32'h0 || apb_reg_psel !== 1'b0) begin failures++; $display("FAIL wr_rsp rdata/psel got=%h/%b exp=0/0", rsp_rdata_o, apb_reg_psel); end
        @(negedge p_clk); #1;
        checks++; if (rsp_valid_o !== 2'b00 || apb_reg_paddr !== 32'h0) begin failures++; $display("FAIL wr_after rsp/paddr got=%b/%h exp=00/0", rsp_valid_o, apb_reg_paddr); end
    endtask

    task automatic test_read_wait();
        @(negedge p_clk);
        apb_reg_pready = 1'b0;
        set_req(1, 1'b0, 32'h0, 32'hFFFF_FFFF, 4'hF);
        req_valid_i = 2'b10;
        #1;
        checks++; if (req_ready_o !== 2'b10) begin failures++; $display("FAIL rd_ready got=%b exp=10", req_ready_o); end
        @(negedge p_clk); req_valid_i = 2'b00; #1;
        checks++; if (apb_reg_paddr !== 32'h0013_0000 || apb_reg_pwrite !== 1'b0) begin failures++; $display("FAIL rd_setup paddr/pwrite got=%h/%b exp=00130000/0", apb_reg_paddr, apb_reg_pwrite); end
        checks++; if (apb_reg_pstrb !== 4'h0) begin failures++; $display("FAIL rd_pstrb got=%h exp=0", apb_reg_pstrb); end
        @(negedge p_clk); #1;
        checks++; if (apb_reg_penable !== 1'b1 || rsp_valid_o !== 2'b00) begin failures++; $display("FAIL rd_wait1 pen/rsp got=%b/%b exp=1/00", apb_reg_penable, rsp_valid_o); end
        @(negedge p_clk); #1;
        checks++; if (apb_reg_penable !== 1'b1 || rsp_valid_o !== 2'b00) begin failures++; $display("FAIL rd_wait2 pen/rsp got=%b/%b exp=1/00", apb_reg_penable, rsp_valid_o); end
        @(negedge p_clk);
        apb_reg_pready = 1'b1;
        apb_reg_prdata = 32'h1234;
        #1;
        checks++; if (apb_reg_psel !== 1'b1 || apb_reg_penable !== 1'b1) begin failures++; $display("FAIL rd_wait3 psel/pen got=%b%b exp=11", apb_reg_psel, apb_reg_penable); end
        @(negedge p_clk); #1;
        checks++; if (rsp_valid_o !== 2'b10 || rsp_rdata_o !== 32'h1234 || rsp_err_o !== 2'd0) begin failures++; $display("FAIL rd_rsp got=%b/%h/%0d exp=10/00001234/0", rsp_valid_o, rsp_rdata_o, rsp_err_o); end
        apb_reg_prdata = 32'h0;
    endtask

    task automatic test_round_robin();
        int         n_acc = 0;
        int         n_rsp = 0;
        logic [1:0] last  = 2'b00;
        logic [1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        set_req(0, 1'b1, 32'h40, 32'h1111_0000, 4'hF);
        set_req(1, 1'b1, 32'h44, 32'h2222_0000, 4'h3);
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge p_clk);
            if (cyc == 0) req_valid_i = 2'b11;
            if (n_acc >= 4) req_valid_i = 2'b00;
            #1;
            if (req_ready_o !== 2'b00) begin
                if (n_acc < 4) begin
                    checks++; if (req_ready_o !== exp_g[n_acc]) begin failures++; $display("FAIL rr_grant%0d got=%b exp=%b", n_acc, req_ready_o, exp_g[n_acc]); end
                end
                last = req_ready_o;
                n_acc++;
            end
            if (rsp_valid_o !== 2'b00) begin
                checks++; if (rsp_valid_o !== last) begin failures++; $display("FAIL rr_rsp got=%b exp=%b", rsp_valid_o, last); end
                n_rsp++;
            end
        end
        checks++; if (n_acc != 4) begin failures++; $display("FAIL rr_accepts got=%0d exp=4", n_acc); end
        checks++; if (n_rsp != 4) begin failures++; $display("FAIL rr_responses got=%0d exp=4", n_rsp); end
    endtask

    task automatic test_decode();
        // misaligned offset
        @(negedge p_clk);
        set_req(0, 1'b1, 32'h2, 32'hDEAD, 4'hF);
        req_valid_i = 2'b01;
        #1;
        checks++; if (req_ready_o !== 2'b01) begin failures++; $display("FAIL dec_a_ready got=%b exp=01", req_ready_o); end
        @(negedge p_clk); req_valid_i = 2'b00; #1;
        checks++; if (rsp_valid_o !== 2'b01 || rsp_err_o !== 2'd3 || rsp_rdata_o !== 32'h0) begin failures++; $display("FAIL dec_a_rsp got=%b/%0d/%h exp=01/3/0", rsp_valid_o, rsp_err_o, rsp_rdata_o); end
        checks++; if (apb_reg_psel !== 1'b0) begin failures++; $display("FAIL dec_a_psel got=%b exp=0", apb_reg_psel); end
        @(negedge p_clk); #1;
        checks++; if (apb_reg_psel !== 1'b0 || rsp_valid_o !== 2'b00) begin failures++; $display("FAIL dec_a_after psel/rsp got=%b/%b exp=0/00", apb_reg_psel, rsp_valid_o); end
        // first offset past the bank
        @(negedge p_clk);
        set_req(1, 1'b0, 32'h558, 32'h0, 4'h0);
        req_valid_i = 2'b10;
        #1;
        checks++; if (req_ready_o !== 2'b10) begin failures++; $display("FAIL dec_b_ready got=%b exp=10", req_ready_o); end
        @(negedge p_clk); req_valid_i = 2'b00; #1;
        checks++; if (rsp_valid_o !== 2'b10 || rsp_err_o !== 2'd3 || apb_reg_psel !== 1'b0) begin failures++; $display("FAIL dec_b_rsp got=%b/%0d/%b exp=10/3/0", rsp_valid_o, rsp_err_o, apb_reg_psel); end
        // last register in the bank
        @(negedge p_clk);
        set_req(0, 1'b0, 32'h554, 32'h0, 4'h0);
        apb_reg_prdata = 32'hBEEF;
        req_valid_i = 2'b01;
        #1;
        checks++; if (req_ready_o !== 2'b01) begin failures++; $display("FAIL dec_c_ready got=%b exp=01", req_ready_o); end
        @(negedge p_clk); req_valid_i = 2'b00; #1;
        checks++; if (apb_reg_psel !== 1'b1 || apb_reg_paddr !== 32'h0013_0554) begin failures++; $display("FAIL dec_c_setup psel/paddr got=%b/%h exp=1/00130554", apb_reg_psel, apb_reg_paddr); end
        @(negedge p_clk);
        @(negedge p_clk); #1;
        checks++; if (rsp_valid_o !== 2'b01 || rsp_err_o !== 2'd0 || rsp_rdata_o !== 32'hBEEF) begin failures++; $display("FAIL dec_c_rsp got=%b/%0d/%h exp=01/0/0000beef", rsp_valid_o, rsp_err_o, rsp_rdata_o); end
        apb_reg_prdata = 32'h0;
    endtask

    task automatic test_timeout();
        @(negedge p_clk);
        apb_reg_pready = 1'b0;
        apb_reg_prdata = 32'hCAFE;
        set_req(1, 1'b1, 32'h20, 32'h9999, 4'hF);
        req_valid_i = 2'b10;
        #1;
        checks++; if (req_ready_o !== 2'b10) begin failures++; $display("FAIL tmo_ready got=%b exp=10", req_ready_o); end
        @(negedge p_clk); req_valid_i = 2'b00;
        repeat (16) @(negedge p_clk);
        #1;
        checks++; if (apb_reg_psel !== 1'b1 || apb_reg_penable !== 1'b1 || rsp_valid_o !== 2'b00) begin failures++; $display("FAIL tmo_16th psel/pen/rsp got=%b%b/%b exp=11/00", apb_reg_psel, apb_reg_penable, rsp_valid_o); end
        @(negedge p_clk); #1;
        checks++; if (apb_reg_psel !== 1'b0 || apb_reg_penable !== 1'b0) begin failures++; $display("FAIL tmo_drop psel/pen got=%b%b exp=00", apb_reg_psel, apb_reg_penable); end
        checks++; if (rsp_valid_o !== 2'b10 || rsp_err_o !== 2'd2 || rsp_rdata_o !== 32'h0) begin failures++; $display("FAIL tmo_rsp got=%b/%0d/%h exp=10/2/0", rsp_valid_o, rsp_err_o, rsp_rdata_o); end
        // next command proceeds normally
        apb_reg_pready = 1'b1;
        @(negedge p_clk);
        set_req(0, 1'b0, 32'h4, 32'h0, 4'h0);
        apb_reg_prdata = 32'h55;
        req_valid_i = 2'b01;
        #1;
        checks++; if (req_ready_o !== 2'b01) begin failures++; $display("FAIL tmo_next_ready got=%b exp=01", req_ready_o); end
        @(negedge p_clk); req_valid_i = 2'b00;
        @(negedge p_clk);
        @(negedge p_clk); #1;
        checks++; if (rsp_valid_o !== 2'b01 || rsp_err_o !== 2'd0 || rsp_rdata_o !== 32'h55) begin failures++; $display("FAIL tmo_next_rsp got=%b/%0d/%h exp=01/0/00000055", rsp_valid_o, rsp_err_o, rsp_rdata_o); end
        // pready arriving on the limit cycle is a success
        @(negedge p_clk);
        apb_reg_pready = 1'b0;
        apb_reg_prdata = 32'h77;
        set_req(1, 1'b0, 32'h8, 32'h0, 4'h0);
        req_valid_i = 2'b10;
        @(negedge p_clk); req_valid_i = 2'b00;
        repeat (16) @(negedge p_clk);
        apb_reg_pready = 1'b1;
        @(negedge p_clk); #1;
        checks++; if (rsp_valid_o !== 2'b10 || rsp_err_o !== 2'd0 || rsp_rdata_o !== 32'h77) begin failures++; $display("FAIL tmo_edge_rsp got=%b/%0d/%h exp=10/0/00000077", rsp_valid_o, rsp_err_o, rsp_rdata_o); end
        apb_reg_prdata = 32'h0;
    endtask

    task automatic test_slverr();
        @(negedge p_clk);
        apb_reg_pslverr = 1'b1;
        set_req(1, 1'b1, 32'hC, 32'h4321, 4'h1);
        req_valid_i = 2'b10;
        @(negedge p_clk); req_valid_i = 2'b00;
        @(negedge p_clk);
        @(negedge p_clk); #1;
        checks++; if (rsp_valid_o !== 2'b10 || rsp_err_o !== 2'd1 || rsp_rdata_o !== 32'h0) begin failures++; $display("FAIL slverr_rsp got=%b/%0d/%h exp=10/1/0", rsp_valid_o, rsp_err_o, rsp_rdata_o); end
        apb_reg_pslverr = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge p_clk);
        apb_reg_pready = 1'b0;
        set_req(0, 1'b0, 32'hC, 32'h0, 4'h0);
        req_valid_i = 2'b01;
        #1;
        checks++; if (req_ready_o !== 2'b01) begin failures++; $display("FAIL rstm_ready got=%b exp=01", req_ready_o); end
        @(negedge p_clk); req_valid_i = 2'b00;
        @(negedge p_clk); #1;
        checks++; if (apb_reg_penable !== 1'b1) begin failures++; $display("FAIL rstm_access got=%b exp=1", apb_reg_penable); end
        p_rst_n = 1'b0;
        @(negedge p_clk); #1;
        checks++; if (apb_reg_psel !== 1'b0 || apb_reg_penable !== 1'b0 || apb_reg_paddr !== 32'h0 || apb_reg_pwrite !== 1'b0) begin failures++; $display("FAIL rstm_apb got=%b%b/%h/%b exp=00/0/0", apb_reg_psel, apb_reg_penable, apb_reg_paddr, apb_reg_pwrite); end
        checks++; if (rsp_valid_o !== 2'b00) begin failures++; $display("FAIL rstm_rsp got=%b exp=00", rsp_valid_o); end
        apb_reg_pready = 1'b1;
        @(negedge p_clk); #1;
        checks++; if (rsp_valid_o !== 2'b00) begin failures++; $display("FAIL rstm_rsp2 got=%b exp=00", rsp_valid_o); end
        p_rst_n = 1'b1;
        // pointer was at requester 1 before reset; it must be back at 0
        @(negedge p_clk);
        set_req(0, 1'b0, 32'h10, 32'h0, 4'h0);
        set_req(1, 1'b0, 32'h14, 32'h0, 4'h0);
        req_valid_i = 2'b11;
        #1;
        checks++; if (req_ready_o !== 2'b01) begin failures++; $display("FAIL rstm_ptr got=%b exp=01", req_ready_o); end
        @(negedge p_clk); req_valid_i = 2'b00;
        @(negedge p_clk);
        @(negedge p_clk); #1;
        checks++; if (rsp_valid_o !== 2'b01) begin failures++; $display("FAIL rstm_after_rsp got=%b exp=01", rsp_valid_o); end
    endtask

    initial begin
        p_rst_n         = 1'b0;
        req_valid_i     = '0;
        req_write_i     = '0;
        req_offs_i      = '0;
        req_wdata_i     = '0;
        req_strb_i      = '0;
        apb_reg_pready  = 1'b1;
        apb_reg_prdata  = '0;
        apb_reg_pslverr = 1'b0;
        test_reset();
        test_single_write();
        test_read_wait();
        test_round_robin();
        test_decode();
        test_timeout();
        test_slverr();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_apb_reg_cfg_sequencer
`default_nettype wire

// File: doc/apb_reg_cfg_sequencer.md
Name: apb_reg_cfg_sequencer

Overview:
- APB master that shares the 32-bit APB register-bank slave between NUM_REQ requesters, e.g. the core bridge and a boot-time config loader.
- Each requester issues single read/write commands on a valid/ready interface.
- A round-robin arbiter grants one command at a time; the FSM sequences the APB SETUP/ACCESS phases.
- Local address decode, a pready timeout and per-requester response return are included.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- APB_ADDR_WIDTH, 32, APB address width.
- APB_DATA_WIDTH, 32, APB data width.
- NO_APB_REGS, 342, registers in the target bank; the bank uses a 4-byte register stride.
- BASE_ADDR, 32'h0013_0000, slave base address added to the request offset.
- TIMEOUT_CYCLES, 16, maximum ACCESS-phase cycles to wait for pready (>=1).
- STRB_WIDTH, APB_DATA_WIDTH/8, derived; do not override.

Ports:
- p_clk  in  1  clock.
- p_rst_n  in  1  synchronous active-low reset.
- req_valid_i  in  NUM_REQ  command valid, one bit per requester.
- req_ready_o  out  NUM_REQ  command accepted, one-hot or zero.
- req_write_i  in  NUM_REQ  1 = write.
- req_offs_i  in  NUM_REQ x APB_ADDR_WIDTH  byte offset from BASE_ADDR.
- req_wdata_i  in  NUM_REQ x APB_DATA_WIDTH  write data.
- req_strb_i  in  NUM_REQ x STRB_WIDTH  write strobes.
- rsp_valid_o  out  NUM_REQ  one-cycle response pulse to the granted requester.
- rsp_rdata_o  out  APB_DATA_WIDTH  read data, shared bus, valid with rsp_valid_o.
- rsp_err_o  out  2  0 OK, 1 SLVERR, 2 TIMEOUT, 3 DECODE.
- apb_reg_paddr  out  APB_ADDR_WIDTH  APB address.
- apb_reg_pprot  out  3  fixed 3'b000.
- apb_reg_psel  out  1  APB select.
- apb_reg_penable  out  1  APB enable.
- apb_reg_pwrite  out  1  APB direction.
- apb_reg_pwdata  out  APB_DATA_WIDTH  APB write data.
- apb_reg_pstrb  out  STRB_WIDTH  APB strobes; forced to 0 on reads.
- apb_reg_pready  in  1  slave ready.
- apb_reg_prdata  in  APB_DATA_WIDTH  slave read data.
- apb_reg_pslverr  in  1  slave error.

Behaviour:
- Reset (p_rst_n low at a p_clk edge): FSM to IDLE, all outputs 0, RR pointer to requester 0, timeout counter 0. Reset mid-transfer aborts with no response.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready_o is combinational; one bit is high for the RR winner among valid requesters, and only in IDLE.
  - On accept: latch write, offset, wdata, strb and grant index; the RR pointer moves to winner+1 mod NUM_REQ.
  - Decode check on the latched offset: offs[1:0]!=0 or offs>=4*NO_APB_REGS means DECODE. DECODE goes to RESP with err=3, rdata=0, and no APB activity. Otherwise go to SETUP.
- SETUP: psel=1, penable=0; paddr=BASE_ADDR+offs, with wrap-around addition truncated to APB_ADDR_WIDTH. pwrite, pwdata and pstrb are driven from the latches. Next state is ACCESS, unconditionally.
- ACCESS:
  - psel=1, penable=1; all APB outputs are held stable.
  - If pready=1: capture prdata (reads only; writes return 0) and pslverr (err=1 if set), then go to RESP.
  - Otherwise the counter increments. When the counter reaches TIMEOUT_CYCLES-1 with pready still low, drop psel/penable, set err=2 and rdata=0, and go to RESP.
  - pready in the same cycle as the timeout limit counts as success.
- RESP: rsp_valid_o[grant]=1 for exactly one cycle with rdata and err; then IDLE. No new accept occurs in RESP.
- Latency: with pready immediate, accept at cycle T, SETUP T+1, ACCESS T+2, rsp_valid T+3. Throughput is one command per 4 cycles.
- A DECODE error responds at T+1.
- Requesters must hold their fields stable while valid and not ready. After accept, the request fields are don't-care.
- Simultaneous valids: the lowest index at or after the RR pointer wins.
- The APB outputs are 0 outside SETUP/ACCESS, including paddr.

Decomposition:
- Package apb_reg_seq_pkg:
  - state_t enum {IDLE, SETUP, ACCESS, RESP}.
  - err_t enum {ERR_OK, ERR_SLV, ERR_TMO, ERR_DEC} (2-bit).
  - REG_STRIDE=4.
- Sub-module apb_reg_rr_arb (NUM_REQ): inputs req, ptr and en; outputs onehot gnt and gnt_idx.

Test Plan:
- Single write: req0 offs=0x10, wdata=0xA5A5, strb=4'hF, pready tied high. Required response:
  - paddr=0x0013_0010, pwrite=1 at SETUP T+1.
  - penable at T+2.
  - rsp_valid_o=2'b01, err=0 at T+3.
- Read with wait states: req1 read offs=0x0, pready high on the 3rd ACCESS cycle, prdata=0x1234. Required response: rsp_valid_o=2'b10, rdata=0x1234 at T+5, pstrb=0.
- Round-robin: both requesters hold valid for 4 commands. Required response: grant order 0,1,0,1 and exactly one rsp pulse per accept.
- Decode errors:
  - offs=0x2 gives err=3 at T+1 with psel never high.
  - offs=0x558 (4*342) gives err=3.
  - offs=0x554 proceeds to APB.
- Timeout: pready stuck low, TIMEOUT_CYCLES=16. Required response: psel drops after 16 ACCESS cycles, err=2, rdata=0, and the next command is accepted normally.
- SLVERR and reset:
  - pslverr=1 with pready gives err=1.
  - p_rst_n low during ACCESS gives all outputs 0 on the next edge, no rsp pulse, and the pointer returns to requester 0.
